dmem_responder: RTL

- Data-memory responder for the CPU's LW/SW path: the memory end of the load/store request/response interface that the CPU's data path will drive.
- Accepts one word request at a time and serves it after a fixed number of wait states.
- Returns read data, or a write acknowledge, through a held response handshake.
- Flags misaligned or out-of-range accesses with an error response; such accesses never modify memory.

---
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_responder.sv | 105 ++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Load/store request/response bus between the CPU data path (master) and
// the data memory (slave).
interface dmem_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one word request, waits a
// fixed number of cycles, performs the access and holds the response.
//
// Handshakes: a request transfers on a posedge where req_valid && req_ready;
// a response transfers on a posedge where resp_valid && resp_ready. The
// master holds req_* stable until accepted; the responder holds resp_* stable
// until consumed. req_ready and resp_valid are never both high.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  dmem_if.slave      bus,
  output logic [1:0] o_dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_access;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_hi;

  // The access itself always costs one edge after the wait count runs out,
  // so even WAIT_STATES=0 passes through WAIT for a single cycle.
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_idx    = r_addr[AW+1:2];
  assign w_hi     = r_addr >> (AW + 2);
  // Any address bit above the index range is out of range; no wrap-around.
  assign w_err    = (r_addr[1:0] != 2'b00) || (w_hi != 32'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_err   <= w_err;
            r_rdata <= (!r_write && !w_err) ? r_mem[w_idx] : 32'd0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is not reset; a reset before the access edge leaves it untouched
  // because the FSM is forced out of WAIT asynchronously.
  always_ff @(posedge clock) begin
    if (w_access && r_write && !w_err) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign o_dbg_state    = r_state;

  a_ready_valid_excl : assert property (
    @(posedge clock) disable iff (!reset_n) !(bus.req_ready && bus.resp_valid)
  );

endmodule
